// File: rtl/snake_pkg.sv
// Shared state encoding and default PS/2 scan codes for the Snake game-flow controller.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_BLACK = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [7:0] KEY_START_DEF  = 8'h1B;
  localparam logic [7:0] KEY_PAUSE_DEF  = 8'h4D;
  localparam logic [7:0] KEY_RESUME_DEF = 8'h2D;
  localparam logic [7:0] KEY_ESC_DEF    = 8'h76;

endpackage

// File: rtl/snake_tick_gen.sv
// Programmable down-counter producing a one-cycle pulse every 'period' enabled cycles.
// The period input is sampled only when the counter reloads.
module snake_tick_gen #(
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             pulse
);

  logic [DIV_W-1:0] cnt;

  // cnt==0 means freshly cleared: the first enabled cycle loads period-1 so that
  // the first pulse and every later one are exactly 'period' enabled cycles apart.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (en) begin
      pulse <= (cnt == DIV_W'(1));
      if (cnt == '0)
        cnt <= period - DIV_W'(1);
      else if (cnt == DIV_W'(1))
        cnt <= period;
      else
        cnt <= cnt - DIV_W'(1);
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game-flow controller: BLACK/RUN/PAUSE/OVER Moore FSM with move-tick generation,
// level progression, blink timing and game-over hold-off. All outputs registered.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter logic [7:0] KEY_START    = KEY_START_DEF,
  parameter logic [7:0] KEY_PAUSE    = KEY_PAUSE_DEF,
  parameter logic [7:0] KEY_RESUME   = KEY_RESUME_DEF,
  parameter logic [7:0] KEY_ESC      = KEY_ESC_DEF,
  parameter int         DIV_W        = 25,
  parameter int         TICK_BASE    = 2_500_000,
  parameter int         TICK_STEP    = 200_000,
  parameter int         LEVEL_MAX    = 7,
  parameter int         FOOD_PER_LVL = 4,
  parameter int         BLINK_DIV    = 12_500_000,
  parameter int         OVER_HOLD    = 25_000_000,
  localparam int        LVL_W        = $clog2(LEVEL_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       key_code,
  input  logic             key_valid,
  input  logic             died,
  input  logic             ate,
  output logic             init_snake,
  output logic             move_tick,
  output logic             screen_black,
  output logic             screen_pause,
  output logic             screen_over,
  output logic             blink,
  output logic [LVL_W-1:0] level
);

  localparam int               FOOD_W     = (FOOD_PER_LVL > 1) ? $clog2(FOOD_PER_LVL) : 1;
  localparam logic [FOOD_W-1:0] FOOD_LAST = FOOD_W'(FOOD_PER_LVL - 1);
  localparam logic [LVL_W-1:0]  LVL_TOP   = LVL_W'(LEVEL_MAX);
  localparam logic [DIV_W-1:0]  BLINK_LAST = DIV_W'(BLINK_DIV - 1);
  localparam logic [DIV_W-1:0]  HOLD_LAST  = DIV_W'(OVER_HOLD - 1);

  if (LEVEL_MAX < 1 || FOOD_PER_LVL < 1 || BLINK_DIV < 1 || OVER_HOLD < 1) begin : g_bad_param
    $error("snake_game_ctrl: LEVEL_MAX, FOOD_PER_LVL, BLINK_DIV and OVER_HOLD must be >= 1");
  end
  if (TICK_BASE - LEVEL_MAX * TICK_STEP < 2) begin : g_bad_period
    $error("snake_game_ctrl: TICK_BASE - LEVEL_MAX*TICK_STEP must be at least 2");
  end
  if (longint'(TICK_BASE) >= (longint'(1) << DIV_W)) begin : g_bad_tick_w
    $error("snake_game_ctrl: TICK_BASE does not fit DIV_W bits");
  end
  if (longint'(BLINK_DIV) >= (longint'(1) << DIV_W)) begin : g_bad_blink_w
    $error("snake_game_ctrl: BLINK_DIV does not fit DIV_W bits");
  end
  if (longint'(OVER_HOLD) >= (longint'(1) << DIV_W)) begin : g_bad_hold_w
    $error("snake_game_ctrl: OVER_HOLD does not fit DIV_W bits");
  end

  function automatic logic [DIV_W-1:0] period_for(input logic [LVL_W-1:0] lvl);
    int p;
    p = TICK_BASE - int'(lvl) * TICK_STEP;
    return DIV_W'(p);
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic              restart;
  logic              k_start;
  logic              k_pause;
  logic              k_resume;
  logic              k_esc;
  logic              ate_ok;
  logic              enter_blink;
  logic              blink_on;
  logic              hold_done;
  logic              tick_en;
  logic              tick_clr;
  logic [FOOD_W-1:0] food;
  logic [DIV_W-1:0]  blink_cnt;
  logic [DIV_W-1:0]  hold_cnt;
  logic [DIV_W-1:0]  period;

  assign k_start  = key_valid && (key_code == KEY_START);
  assign k_pause  = key_valid && (key_code == KEY_PAUSE);
  assign k_resume = key_valid && (key_code == KEY_RESUME);
  assign k_esc    = key_valid && (key_code == KEY_ESC);

  assign hold_done = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    case (state)
      ST_BLACK: begin
        if (k_start) begin
          state_nxt = ST_RUN;
          restart   = 1'b1;
        end
      end
      ST_RUN: begin
        if (k_esc) begin
          state_nxt = ST_BLACK;
        end else if (died) begin
          state_nxt = ST_OVER;
        end else if (k_start) begin
          state_nxt = ST_RUN;
          restart   = 1'b1;
        end else if (k_pause) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (k_esc) begin
          state_nxt = ST_BLACK;
        end else if (k_start) begin
          state_nxt = ST_RUN;
          restart   = 1'b1;
        end else if (k_resume) begin
          state_nxt = ST_RUN;
        end
      end
      ST_OVER: begin
        if (k_esc) begin
          state_nxt = ST_BLACK;
        end else if (k_start && hold_done) begin
          state_nxt = ST_RUN;
          restart   = 1'b1;
        end
      end
      default: state_nxt = ST_BLACK;
    endcase
  end

  // A simultaneous died (or ESC/restart) masks the food pulse.
  assign ate_ok = (state == ST_RUN) && ate && !died && !k_esc && !restart;

  assign blink_on    = (state_nxt == ST_PAUSE) || (state_nxt == ST_OVER);
  assign enter_blink = blink_on && (state_nxt != state);

  // Counting only while RUN persists freezes the phase across PAUSE.
  assign tick_en  = (state == ST_RUN) && (state_nxt == ST_RUN);
  assign tick_clr = restart || (state_nxt == ST_BLACK) || (state_nxt == ST_OVER);
  assign period   = period_for(level);

  snake_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (tick_en),
    .clr    (tick_clr),
    .period (period),
    .pulse  (move_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_BLACK;
      screen_black <= 1'b1;
      screen_pause <= 1'b0;
      screen_over  <= 1'b0;
      init_snake   <= 1'b0;
      blink        <= 1'b0;
      blink_cnt    <= '0;
      hold_cnt     <= '0;
      level        <= '0;
      food         <= '0;
    end else begin
      state        <= state_nxt;
      screen_black <= (state_nxt == ST_BLACK);
      screen_pause <= (state_nxt == ST_PAUSE);
      screen_over  <= (state_nxt == ST_OVER);
      init_snake   <= restart;

      if (restart) begin
        level <= '0;
        food  <= '0;
      end else if (ate_ok) begin
        if (food == FOOD_LAST) begin
          food <= '0;
          if (level != LVL_TOP)
            level <= level + LVL_W'(1);
        end else begin
          food <= food + FOOD_W'(1);
        end
      end

      if (!blink_on || enter_blink) begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + DIV_W'(1);
      end

      if (state_nxt != ST_OVER || state != ST_OVER)
        hold_cnt <= '0;
      else if (!hold_done)
        hold_cnt <= hold_cnt + DIV_W'(1);
    end
  end

endmodule
